uart_rx_stream: RTL and testbench

Parametrised UART receive engine that replaces the fixed single-line, single-format receiver behind the `uart_rx_conduit` pin. It oversamples the asynchronous line, deframes words of configurable width with optional parity, and buffers them in a show-ahead FIFO. Words leave on a valid/ready stream with per-word error tags, for HPS-side or hex-display consumers in the SoC fabric.

---
 rtl/uart_rx_pkg.sv | 34 +++
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart_rx_stream.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_rx_stream.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;
`endif

  // Error flag positions, counted upward from the top of the data field
  localparam int FRAME_ERR_BIT  = 0;
  localparam int PARITY_ERR_BIT = 1;

  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    int div;
    div = clk_hz / (baud * oversample);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic show-ahead synchronous FIFO: the head word is visible on rd_data
// whenever empty is low, and rd_en consumes it.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  // A write into a full FIFO is only taken when a read frees a slot in the same cycle
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign level   = count;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/uart_rx_stream.sv
// Oversampling UART receiver feeding a show-ahead FIFO with per-word error tags.
// Define UART_RX_PARITY_EN to add a parity bit to the frame and enable out_parity_err.
module uart_rx_stream
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          uart_rx_conduit,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_BITS-1:0]          out_data,
  output logic                          out_frame_err,
  output logic                          out_parity_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  input  logic                          parity_odd
);

  localparam int DIV     = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W   = $clog2(DIV + 1);
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_BITS + 1);
  localparam int ENTRY_W = DATA_BITS + 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  MID_A    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  MID_B    = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  MID_C    = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  rx_state_e            state_q;
  rx_state_e            state_d;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic                 start_edge;
  logic [DIV_W-1:0]     div_cnt;
  logic [OS_W-1:0]      os_cnt;
  logic                 tick;
  logic                 vote_now;
  logic                 samp_a;
  logic                 samp_b;
  logic                 vote;
  logic [DATA_BITS-1:0] shift_q;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 shift_en;
  logic                 push;
  logic                 frame_err;
  logic                 par_err_q;
  logic [ENTRY_W-1:0]   wr_entry;
  logic [ENTRY_W-1:0]   head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 ovf_event;
`ifdef UART_RX_PARITY_EN
  logic                 par_load;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx_conduit;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = rx_prev & ~rx_sync;
  assign tick       = (state_q != IDLE) && (div_cnt == DIV_LAST);
  assign vote_now   = tick && (os_cnt == MID_C);
  assign vote       = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);

  // Both counters sit at zero in IDLE so every frame is timed from its own start edge
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_cnt <= '0;
      os_cnt  <= '0;
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
    end else begin
      if (state_q == IDLE || div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (state_q == IDLE) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
      end
      if (tick && os_cnt == MID_A) begin
        samp_a <= rx_sync;
      end
      if (tick && os_cnt == MID_B) begin
        samp_b <= rx_sync;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    push      = 1'b0;
    frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_load  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
        end
      end
      START: begin
        if (vote_now) begin
          state_d = vote ? IDLE : DATA;
        end
      end
      DATA: begin
        if (vote_now) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (vote_now) begin
          par_load = 1'b1;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (vote_now) begin
          push      = 1'b1;
          frame_err = ~vote;
          // An all-zero word with a low stop bit is a break: park until the line idles
          state_d   = (!vote && shift_q == '0) ? BREAK : IDLE;
        end
      end
      BREAK: begin
        if (rx_sync) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      if (shift_en) begin
        shift_q <= {vote, shift_q[DATA_BITS-1:1]};
      end
      if (state_q == IDLE) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      par_err_q <= 1'b0;
    end else if (state_q == IDLE) begin
      par_err_q <= 1'b0;
    end else if (par_load) begin
      par_err_q <= ((^shift_q) ^ vote) != parity_odd;
    end
  end
`else
  assign par_err_q = 1'b0;
`endif

  always_comb begin
    wr_entry                                 = '0;
    wr_entry[DATA_BITS-1:0]                  = shift_q;
    wr_entry[DATA_BITS + FRAME_ERR_BIT]      = frame_err;
    wr_entry[DATA_BITS + PARITY_ERR_BIT]     = par_err_q;
  end

  uart_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pop       = out_valid & out_ready;
  assign ovf_event = push & fifo_full & ~pop;

  // A fresh drop wins over a clear arriving in the same cycle
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      overflow <= 1'b0;
    end else if (ovf_event) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  assign out_valid     = ~fifo_empty;
  assign out_data      = fifo_empty ? '0 : head[DATA_BITS-1:0];
  assign out_frame_err = ~fifo_empty & head[DATA_BITS + FRAME_ERR_BIT];
`ifdef UART_RX_PARITY_EN
  assign out_parity_err = ~fifo_empty & head[DATA_BITS + PARITY_ERR_BIT];
`else
  logic unused_parity;
  assign unused_parity  = parity_odd ^ head[DATA_BITS + PARITY_ERR_BIT];
  assign out_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream with a scoreboard of expected FIFO words.
// Honours UART_RX_PARITY_EN for frame shape and the parity steps.
module tb_uart_rx_stream;

  localparam int CLK_HZ     = 5_000_000;
  localparam int BAUD       = 100_000;
  localparam int OS         = 16;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int EW         = DATA_BITS + 2;

  localparam int TB_DIV  = CLK_HZ / (BAUD * OS);
  localparam int BIT_CYC = TB_DIV * OS;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam bit PAR_EN    = (PAR_BITS != 0);
  localparam int STOP_IDX  = 1 + DATA_BITS + PAR_BITS;
  localparam int FRAME_CYC = (STOP_IDX + 1) * BIT_CYC;
  // 2 synchronizer flops + edge register, then the stop-bit mid vote, then one cycle to out_valid
  localparam int EXP_LAT   = 3 + (STOP_IDX * OS + OS / 2 + 2) * TB_DIV;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 rx = 1'b1;
  logic                 out_ready = 1'b0;
  logic                 ovf_clr = 1'b0;
  logic                 parity_odd = 1'b0;
  logic                 out_valid;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_frame_err;
  logic                 out_parity_err;
  logic [LVL_W-1:0]     fifo_level;
  logic                 overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  logic valid_prev = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_stream #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .uart_rx_conduit (rx),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_frame_err   (out_frame_err),
    .out_parity_err  (out_parity_err),
    .fifo_level      (fifo_level),
    .overflow        (overflow),
    .ovf_clr         (ovf_clr),
    .parity_odd      (parity_odd)
  );

  // Every accepted head word is compared against the oldest expected entry
  always @(negedge clk) begin
    if (out_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = out_valid;
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_word observed=%h required=no word", {out_parity_err, out_frame_err, out_data});
      end
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        checks++;
        assert ({out_parity_err, out_frame_err, out_data} === exp_e) else begin
          errors++;
          $error("[TB] FAIL word observed=%h required=%h", {out_parity_err, out_frame_err, out_data}, exp_e);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h required=%0h", name, obs, exp);
    end
  endtask

  function automatic logic good_par(input logic [DATA_BITS-1:0] d);
    return (^d) ^ parity_odd;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; par_flip inverts the correct parity bit and is expected as a parity error
  task automatic applyStimulus(input logic [DATA_BITS-1:0] data, input logic stop_bit,
                               input logic par_flip, input logic exp_push);
    if (exp_push) exp_q.push_back({par_flip & PAR_EN, ~stop_bit, data});
    start_cyc = cyc;
    rx = 1'b0;
    idle(BIT_CYC);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = data[i];
      idle(BIT_CYC);
    end
`ifdef UART_RX_PARITY_EN
    rx = good_par(data) ^ par_flip;
    idle(BIT_CYC);
`endif
    rx = stop_bit;
    idle(BIT_CYC);
    rx = 1'b1;
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_data"}, out_data, 0);
    checkOutput({tag, "_frame_err"}, out_frame_err, 0);
    checkOutput({tag, "_parity_err"}, out_parity_err, 0);
    checkOutput({tag, "_level"}, fifo_level, 0);
    checkOutput({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    $display("[TB] DIV=%0d bit=%0d cycles frame=%0d cycles parity=%0d", TB_DIV, BIT_CYC, FRAME_CYC, PAR_BITS);
    idle(3);
    @(negedge clk);
    checkResetState("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    // Single clean word, with out_valid timing relative to the start edge
    out_ready = 1'b1;
    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1);
    checkOutput("a5_latency", rise_cyc - start_cyc, EXP_LAT);
    waitDrain("a5_drain", 20);

    // Short low glitch must be rejected by the start-bit vote
    rx = 1'b0;
    idle(4 * TB_DIV);
    rx = 1'b1;
    idle(2 * BIT_CYC);
    @(negedge clk);
    checkOutput("glitch_level", fifo_level, 0);
    checkOutput("glitch_valid", out_valid, 0);
    @(posedge clk); #1;
    applyStimulus(8'h5A, 1'b1, 1'b0, 1'b1);
    waitDrain("after_glitch_drain", 20);

    // Fill past capacity with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i <= FIFO_DEPTH; i++) begin
      applyStimulus(8'(i), 1'b1, 1'b0, exp_q.size() < FIFO_DEPTH);
    end
    idle(2);
    @(negedge clk);
    checkOutput("full_level", fifo_level, FIFO_DEPTH);
    checkOutput("full_overflow", overflow, 1);
    checkOutput("full_valid", out_valid, 1);
    checkOutput("full_head", out_data, 8'h00);
    @(posedge clk); #1;
    idle(5);
    @(negedge clk);
    checkOutput("stall_head_stable", out_data, 8'h00);
    checkOutput("stall_level_stable", fifo_level, FIFO_DEPTH);
    @(posedge clk); #1;
    out_ready = 1'b1;
    waitDrain("overflow_drain", 4 * FIFO_DEPTH);
    @(negedge clk);
    checkOutput("drained_level", fifo_level, 0);
    checkOutput("overflow_sticky", overflow, 1);
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    checkOutput("overflow_cleared", overflow, 0);
    @(posedge clk); #1;

    // Framing error on a non-zero word, then a long break
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1);
    idle(BIT_CYC);
    waitDrain("frame_err_drain", 20);
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    rx = 1'b0;
    idle(3 * FRAME_CYC);
    @(negedge clk);
    checkOutput("break_single_word", exp_q.size(), 0);
    checkOutput("break_level", fifo_level, 0);
    @(posedge clk); #1;
    rx = 1'b1;
    idle(2 * BIT_CYC);
    applyStimulus(8'h81, 1'b1, 1'b0, 1'b1);
    waitDrain("after_break_drain", 20);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
    waitDrain("even_bad_parity", 20);
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b1);
    waitDrain("even_good_parity", 20);
    parity_odd = 1'b1;
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b1);
    waitDrain("odd_good_parity", 20);
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
    waitDrain("odd_bad_parity", 20);
    parity_odd = 1'b0;
`endif

    // Reset in the middle of a frame with a word already buffered
    out_ready = 1'b0;
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b1);
    idle(2);
    @(negedge clk);
    checkOutput("prereset_level", fifo_level, 1);
    @(posedge clk); #1;
    rx = 1'b0;
    idle(BIT_CYC);
    for (int i = 0; i < 3; i++) begin
      rx = (i % 2 == 0) ? 1'b1 : 1'b0;
      idle(BIT_CYC);
    end
    rx = 1'b0;
    idle(BIT_CYC / 2);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkResetState("midframe_reset");
    @(posedge clk); #1;
    rx = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(BIT_CYC);
    out_ready = 1'b1;
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b1);
    waitDrain("post_reset_drain", 20);
    @(negedge clk);
    checkOutput("post_reset_level", fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
